// File: rtl/usr_irq_pkg.sv
// Shared types and widths for the user-interrupt arbiter slice.
package usr_irq_pkg;

  localparam int unsigned IRQ_VEC_W = 12;
  localparam int unsigned IRQ_FNC_W = 8;
  localparam int unsigned STAT_W    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBackoff
  } arb_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-one search over a request vector, starting at ptr and wrapping.
module rr_pick #(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      int unsigned         j;
      logic [IDX_W-1:0]    jj;
      j = 32'(ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any       = 1'b1;
        grant_idx = jj;
      end
    end
  end

endmodule

// File: rtl/usr_irq_arb.sv
// Multi-source arbiter onto the QDMA usr_irq port with bounded retry, backoff and timeout.
module usr_irq_arb
  import usr_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned BACKOFF   = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                           axil_aclk,
  input  logic                           axil_aresetn,
  input  logic [NUM_SRC-1:0]             src_vld,
  output logic [NUM_SRC-1:0]             src_rdy,
  input  logic [NUM_SRC*IRQ_VEC_W-1:0]   src_vec,
  input  logic [NUM_SRC*IRQ_FNC_W-1:0]   src_fnc,
  output logic [NUM_SRC-1:0]             src_done,
  output logic [NUM_SRC-1:0]             src_err,
  output logic                           usr_irq_in_vld,
  output logic [IRQ_VEC_W-1:0]           usr_irq_in_vec,
  output logic [IRQ_FNC_W-1:0]           usr_irq_in_fnc,
  input  logic                           usr_irq_out_ack,
  input  logic                           usr_irq_out_fail,
  output logic [STAT_W-1:0]              stat_ack_cnt,
  output logic [STAT_W-1:0]              stat_err_cnt,
  output logic [STAT_W-1:0]              stat_retry_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  BO_LAST    = 8'(BACKOFF - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SRC - 1);

  // Per-source slots
  logic [NUM_SRC-1:0]   pending_q, pending_d, accept, avail;
  logic [IRQ_VEC_W-1:0] slot_vec_q [NUM_SRC];
  logic [IRQ_FNC_W-1:0] slot_fnc_q [NUM_SRC];

  // Arbiter state
  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]           retry_q, retry_d;
  logic [15:0]          timer_q, timer_d;
  logic [7:0]           bo_q, bo_d;
  logic                 vld_q, vld_d;
  logic [IRQ_VEC_W-1:0] vec_q, vec_d;
  logic [IRQ_FNC_W-1:0] fnc_q, fnc_d;
  logic [NUM_SRC-1:0]   done_q, done_d, err_q, err_d;
  logic [STAT_W-1:0]    ack_cnt_q, ack_cnt_d, err_cnt_q, err_cnt_d, rty_cnt_q, rty_cnt_d;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  assign accept    = src_vld & ~pending_q;
  // done/err pulses clear the slot next edge; mask it now so IDLE cannot re-grant it.
  assign avail     = pending_q & ~(done_q | err_q);
  assign pending_d = avail | accept;

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      pending_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_vec_q[i] <= '0;
        slot_fnc_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i]) begin
          slot_vec_q[i] <= src_vec[IRQ_VEC_W*i +: IRQ_VEC_W];
          slot_fnc_q[i] <= src_fnc[IRQ_FNC_W*i +: IRQ_FNC_W];
        end
      end
    end
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req       (avail),
    .ptr       (rr_ptr_q),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    bo_d      = bo_q;
    vld_d     = vld_q;
    vec_d     = vec_q;
    fnc_d     = fnc_q;
    done_d    = '0;
    err_d     = '0;
    ack_cnt_d = ack_cnt_q;
    err_cnt_d = err_cnt_q;
    rty_cnt_d = rty_cnt_q;

    unique case (state_q)
      StIdle: begin
        vld_d = 1'b0;
        if (pick_any) begin
          grant_d  = pick_idx;
          vec_d    = slot_vec_q[pick_idx];
          fnc_d    = slot_fnc_q[pick_idx];
          rr_ptr_d = (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_W'(1);
          retry_d  = '0;
          timer_d  = '0;
          vld_d    = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        timer_d = timer_q + 16'd1;
        // ack has priority over a simultaneous fail
        if (usr_irq_out_ack) begin
          vld_d            = 1'b0;
          done_d[grant_q]  = 1'b1;
          ack_cnt_d        = sat_inc(ack_cnt_q);
          state_d          = StIdle;
        end else if (usr_irq_out_fail || (timer_q == TIMER_LAST)) begin
          vld_d = 1'b0;
          if (retry_q < RETRY_MAX) begin
            retry_d   = retry_q + 4'd1;
            rty_cnt_d = sat_inc(rty_cnt_q);
            bo_d      = '0;
            state_d   = StBackoff;
          end else begin
            err_d[grant_q] = 1'b1;
            err_cnt_d      = sat_inc(err_cnt_q);
            state_d        = StIdle;
          end
        end
      end
      StBackoff: begin
        vld_d = 1'b0;
        if (bo_q == BO_LAST) begin
          timer_d = '0;
          vld_d   = 1'b1;
          state_d = StIssue;
        end else begin
          bo_d = bo_q + 8'd1;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      bo_q      <= '0;
      vld_q     <= 1'b0;
      vec_q     <= '0;
      fnc_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      ack_cnt_q <= '0;
      err_cnt_q <= '0;
      rty_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      bo_q      <= bo_d;
      vld_q     <= vld_d;
      vec_q     <= vec_d;
      fnc_q     <= fnc_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ack_cnt_q <= ack_cnt_d;
      err_cnt_q <= err_cnt_d;
      rty_cnt_q <= rty_cnt_d;
    end
  end

  assign src_rdy        = ~pending_q;
  assign src_done       = done_q;
  assign src_err        = err_q;
  assign usr_irq_in_vld = vld_q;
  assign usr_irq_in_vec = vec_q;
  assign usr_irq_in_fnc = fnc_q;
  assign stat_ack_cnt   = ack_cnt_q;
  assign stat_err_cnt   = err_cnt_q;
  assign stat_retry_cnt = rty_cnt_q;

endmodule

// File: tb/tb_usr_irq_arb.sv
// Scoreboard bench for usr_irq_arb: directed requests, scripted QDMA responder, queued checks.
module tb_usr_irq_arb;

  localparam int unsigned NS = 4;
  localparam int unsigned MR = 3;
  localparam int unsigned BO = 5;
  localparam int unsigned TO = 20;

  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_FAIL = 2;
  localparam int K_BOTH = 3;

  logic            clk;
  logic            rst_n;
  logic [NS-1:0]   src_vld, src_rdy, src_done, src_err;
  logic [NS*12-1:0] src_vec;
  logic [NS*8-1:0] src_fnc;
  logic            vld, ack, fail;
  logic [11:0]     vec;
  logic [7:0]      fnc;
  logic [15:0]     ack_cnt, err_cnt, rty_cnt;

  usr_irq_arb #(
    .NUM_SRC   (NS),
    .MAX_RETRY (MR),
    .BACKOFF   (BO),
    .TIMEOUT   (TO)
  ) dut (
    .axil_aclk        (clk),
    .axil_aresetn     (rst_n),
    .src_vld          (src_vld),
    .src_rdy          (src_rdy),
    .src_vec          (src_vec),
    .src_fnc          (src_fnc),
    .src_done         (src_done),
    .src_err          (src_err),
    .usr_irq_in_vld   (vld),
    .usr_irq_in_vec   (vec),
    .usr_irq_in_fnc   (fnc),
    .usr_irq_out_ack  (ack),
    .usr_irq_out_fail (fail),
    .stat_ack_cnt     (ack_cnt),
    .stat_err_cnt     (err_cnt),
    .stat_retry_cnt   (rty_cnt)
  );

  typedef struct {
    logic [11:0] vec;
    logic [7:0]  fnc;
    int          abs_c;
    int          gap;
    int          hi;
  } iss_t;

  typedef struct {
    logic [NS-1:0] done;
    logic [NS-1:0] err;
  } cmp_t;

  typedef struct {
    int dly;
    int kind;
  } rsp_t;

  iss_t iss_q[$];
  cmp_t cmp_q[$];
  rsp_t rsp_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_iss(input logic [11:0] v, input logic [7:0] f, input int a, input int g,
                         input int h);
    iss_t e;
    e.vec = v; e.fnc = f; e.abs_c = a; e.gap = g; e.hi = h;
    iss_q.push_back(e);
  endtask

  task automatic exp_cmp(input logic [NS-1:0] d, input logic [NS-1:0] e);
    cmp_t c;
    c.done = d; c.err = e;
    cmp_q.push_back(c);
  endtask

  task automatic exp_rsp(input int d, input int k);
    rsp_t r;
    r.dly = d; r.kind = k;
    rsp_q.push_back(r);
  endtask

  task automatic req(input logic [NS-1:0] m, input logic [NS*12-1:0] v,
                     input logic [NS*8-1:0] f, output int n);
    @(negedge clk);
    src_vld = m; src_vec = v; src_fnc = f;
    n = cyc;
    @(negedge clk);
    src_vld = '0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      @(negedge clk);
      if (iss_q.size() == 0 && cmp_q.size() == 0 && !vld && src_done == '0 && src_err == '0)
        quiet++;
      else
        quiet = 0;
    end
    chk("idle_wait", 32'(quiet), 32'd4);
  endtask

  // QDMA responder: one scripted reaction per vld rising edge
  initial begin : responder
    logic r_prev;
    rsp_t r;
    r_prev = 1'b0;
    ack = 1'b0;
    fail = 1'b0;
    forever begin
      @(negedge clk);
      if (vld && !r_prev && rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        if (r.kind != K_NONE) begin
          repeat (r.dly) @(negedge clk);
          ack  = (r.kind == K_ACK)  || (r.kind == K_BOTH);
          fail = (r.kind == K_FAIL) || (r.kind == K_BOTH);
          @(negedge clk);
          ack  = 1'b0;
          fail = 1'b0;
        end
      end
      r_prev = vld;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an issue or a completion
  initial begin : monitor
    logic          m_prev;
    int            rise_c, fall_c;
    iss_t          cur;
    cmp_t          c;
    logic [NS-1:0] rdy_chk;
    m_prev = 1'b0; rise_c = 0; fall_c = 0; rdy_chk = '0;
    cur.hi = -1;
    forever begin
      @(negedge clk);
      if (rdy_chk != '0) begin
        chk("rdy_after_done", 32'(src_rdy & rdy_chk), 32'(rdy_chk));
        rdy_chk = '0;
      end
      if (vld && !m_prev) begin
        if (iss_q.size() == 0) begin
          chk("unexpected_issue", 32'(vec), 32'hFFFF_FFFF);
          cur.hi = -1;
        end else begin
          cur = iss_q.pop_front();
          chk("issue_vec", 32'(vec), 32'(cur.vec));
          chk("issue_fnc", 32'(fnc), 32'(cur.fnc));
          if (cur.abs_c >= 0) chk("issue_latency", cyc, cur.abs_c);
          if (cur.gap >= 0) chk("issue_gap", cyc - fall_c, cur.gap);
        end
        rise_c = cyc;
      end
      if (!vld && m_prev) begin
        if (cur.hi >= 0) chk("vld_high_len", cyc - rise_c, cur.hi);
        fall_c = cyc;
      end
      if (src_done != '0 || src_err != '0) begin
        if (cmp_q.size() == 0) begin
          chk("unexpected_completion", 32'({src_done, src_err}), 32'hFFFF_FFFF);
        end else begin
          c = cmp_q.pop_front();
          chk("src_done", 32'(src_done), 32'(c.done));
          chk("src_err", 32'(src_err), 32'(c.err));
          chk("done_at_vld_fall", 32'({m_prev, vld}), 32'b10);
          chk("rdy_low_at_done", 32'(src_rdy & (src_done | src_err)), 32'd0);
          rdy_chk = src_done | src_err;
        end
      end
      m_prev = vld;
    end
  end

  initial begin : stim
    int n;
    rst_n = 1'b0; src_vld = '0; src_vec = '0; src_fnc = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_vec", 32'(vec), 32'd0);
    chk("rst_fnc", 32'(fnc), 32'd0);
    chk("rst_done_err", 32'({src_done, src_err}), 32'd0);
    chk("rst_rdy", 32'(src_rdy), 32'hF);
    chk("rst_stats", 32'({ack_cnt, err_cnt}) | 32'(rty_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All four at once, immediate ack: 0,1,2,3 with one idle cycle between
    req(4'hF, {12'h103, 12'h102, 12'h101, 12'h100}, {8'h13, 8'h12, 8'h11, 8'h10}, n);
    exp_iss(12'h100, 8'h10, n + 2, -1, 1);
    exp_iss(12'h101, 8'h11, -1, 1, 1);
    exp_iss(12'h102, 8'h12, -1, 1, 1);
    exp_iss(12'h103, 8'h13, -1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      exp_rsp(0, K_ACK);
      exp_cmp(NS'(1 << i), '0);
    end
    wait_idle();
    chk("ack_cnt_rr", 32'(ack_cnt), 32'd4);

    // Single source 0, ack 3 cycles after vld rises
    req(4'h1, 48'h005, 32'h01, n);
    exp_iss(12'h005, 8'h01, n + 2, -1, 4);
    exp_rsp(3, K_ACK);
    exp_cmp(4'h1, '0);
    wait_idle();
    chk("ack_cnt_single", 32'(ack_cnt), 32'd5);

    // Move pointer to 2 via source 1, then 0,2,3 together grant 2 first
    req(4'h2, {12'h000, 12'h000, 12'h011, 12'h000}, {8'h00, 8'h00, 8'h21, 8'h00}, n);
    exp_iss(12'h011, 8'h21, n + 2, -1, 1);
    exp_rsp(0, K_ACK);
    exp_cmp(4'h2, '0);
    wait_idle();
    req(4'hD, {12'h203, 12'h202, 12'h000, 12'h200}, {8'h33, 8'h32, 8'h00, 8'h30}, n);
    exp_iss(12'h202, 8'h32, n + 2, -1, 1);
    exp_iss(12'h203, 8'h33, -1, 1, 1);
    exp_iss(12'h200, 8'h30, -1, 1, 1);
    exp_rsp(0, K_ACK); exp_rsp(0, K_ACK); exp_rsp(0, K_ACK);
    exp_cmp(4'h4, '0); exp_cmp(4'h8, '0); exp_cmp(4'h1, '0);
    wait_idle();
    chk("ack_cnt_round2", 32'(ack_cnt), 32'd9);

    // Two fails then ack on source 3
    req(4'h8, {12'h3A3, 36'h0}, {8'h3C, 24'h0}, n);
    exp_iss(12'h3A3, 8'h3C, n + 2, -1, 2);
    exp_iss(12'h3A3, 8'h3C, -1, BO, 2);
    exp_iss(12'h3A3, 8'h3C, -1, BO, 1);
    exp_rsp(1, K_FAIL); exp_rsp(1, K_FAIL); exp_rsp(0, K_ACK);
    exp_cmp(4'h8, '0);
    wait_idle();
    chk("retry_cnt_2fail", 32'(rty_cnt), 32'd2);
    chk("err_cnt_2fail", 32'(err_cnt), 32'd0);
    chk("ack_cnt_2fail", 32'(ack_cnt), 32'd10);

    // Always fail on source 0: 4 issues then err
    req(4'h1, 48'h0F0, 32'h0E, n);
    exp_iss(12'h0F0, 8'h0E, n + 2, -1, 1);
    for (int i = 0; i < 3; i++) exp_iss(12'h0F0, 8'h0E, -1, BO, 1);
    for (int i = 0; i < 4; i++) exp_rsp(0, K_FAIL);
    exp_cmp('0, 4'h1);
    wait_idle();
    chk("err_cnt_fail", 32'(err_cnt), 32'd1);
    chk("retry_cnt_fail", 32'(rty_cnt), 32'd5);

    // Silent QDMA on source 2: timeout each issue, ends in err
    req(4'h4, {12'h000, 12'h2C2, 24'h0}, {8'h00, 8'h2D, 16'h0}, n);
    exp_iss(12'h2C2, 8'h2D, n + 2, -1, TO);
    for (int i = 0; i < 3; i++) exp_iss(12'h2C2, 8'h2D, -1, BO, TO);
    for (int i = 0; i < 4; i++) exp_rsp(0, K_NONE);
    exp_cmp('0, 4'h4);
    wait_idle();
    chk("err_cnt_timeout", 32'(err_cnt), 32'd2);
    chk("retry_cnt_timeout", 32'(rty_cnt), 32'd8);

    // ack and fail together: ack wins
    req(4'h2, {24'h0, 12'h1B1, 12'h0}, {16'h0, 8'h1B, 8'h0}, n);
    exp_iss(12'h1B1, 8'h1B, n + 2, -1, 3);
    exp_rsp(2, K_BOTH);
    exp_cmp(4'h2, '0);
    wait_idle();
    chk("ack_cnt_both", 32'(ack_cnt), 32'd11);
    chk("retry_cnt_both", 32'(rty_cnt), 32'd8);

    // src_vld on a pending slot is ignored
    req(4'h1, 48'h0AA, 32'h0A, n);
    exp_iss(12'h0AA, 8'h0A, n + 2, -1, 7);
    exp_rsp(6, K_ACK);
    exp_cmp(4'h1, '0);
    repeat (2) @(negedge clk);
    chk("rdy_low_pending", 32'(src_rdy[0]), 32'd0);
    src_vld = 4'h1; src_vec = 48'h0BB; src_fnc = 32'h0B;
    @(negedge clk);
    src_vld = '0;
    wait_idle();
    chk("ack_cnt_ignored", 32'(ack_cnt), 32'd12);

    // Reset mid-ISSUE drops the interrupt silently
    req(4'h8, {12'h3E3, 36'h0}, {8'h3F, 24'h0}, n);
    exp_iss(12'h3E3, 8'h3F, n + 2, -1, -1);
    exp_rsp(0, K_NONE);
    repeat (4) @(negedge clk);
    chk("vld_before_reset", 32'(vld), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_vld", 32'(vld), 32'd0);
    chk("reset_rdy", 32'(src_rdy), 32'hF);
    chk("reset_ack_cnt", 32'(ack_cnt), 32'd0);
    chk("reset_retry_err", 32'({rty_cnt, err_cnt}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/usr_irq_arb.md
# usr_irq_arb

Multi-source user-interrupt arbiter between the per-function interrupt generators and the QDMA `usr_irq` port. It captures up to `NUM_SRC` independent requests, picks one round-robin, and drives the QDMA vld/vec/fnc handshake. It retries a bounded number of times on `fail` or timeout, and reports completion per source. Each generator instance connects to one source slot instead of driving the QDMA port directly.

## Interface
- `NUM_SRC`, 4: number of request sources, 2..16
- `MAX_RETRY`, 3: re-issues allowed after the first attempt, 0..15
- `BACKOFF`, 16: idle cycles between a fail/timeout and the retry, 1..255
- `TIMEOUT`, 1024: cycles `usr_irq_in_vld` may stay high without ack/fail, 2..65535
- `axil_aclk`  in  1  clock
- `axil_aresetn`  in  1  reset; asynchronous, active-low
- `src_vld`  in  NUM_SRC  request strobe per source
- `src_rdy`  out  NUM_SRC  source slot empty; request accepted on `src_vld & src_rdy`
- `src_vec`  in  NUM_SRC*12  vector per source, slice i = bits [12i+11:12i]
- `src_fnc`  in  NUM_SRC*8  function per source, slice i = bits [8i+7:8i]
- `src_done`  out  NUM_SRC  1-cycle pulse: source's interrupt acked
- `src_err`  out  NUM_SRC  1-cycle pulse: source's interrupt abandoned
- `usr_irq_in_vld`  out  1  to QDMA
- `usr_irq_in_vec`  out  12  to QDMA
- `usr_irq_in_fnc`  out  8  to QDMA
- `usr_irq_out_ack`  in  1  from QDMA
- `usr_irq_out_fail`  in  1  from QDMA
- `stat_ack_cnt`  out  16  total acks, saturating
- `stat_err_cnt`  out  16  total abandoned requests, saturating
- `stat_retry_cnt`  out  16  total re-issues, saturating

## Operation
- **Per-source slot:**
  - On accept, latch vec/fnc and set `pending[i]`.
  - `src_rdy[i] = ~pending[i]`, driven from the register.
  - `pending[i]` clears on that source's done or err.
- **FSM states:** IDLE, ISSUE, BACKOFF.
  - **IDLE:** if any `pending`, grant the first pending index at or after `rr_ptr` (wrapping at `NUM_SRC`).
    - Register the grant index and its vec/fnc to the outputs.
    - Set `rr_ptr <= grant+1` (mod `NUM_SRC`) and clear `retry_cnt`.
    - Go to ISSUE.
  - **ISSUE:** `usr_irq_in_vld=1`, vec/fnc held stable; `timer` counts up from 0.
    - ack: pulse `src_done[grant]`, clear pending, increment `stat_ack_cnt`, go to IDLE.
    - fail, or `timer==TIMEOUT-1`: if `retry_cnt<MAX_RETRY`, increment `retry_cnt` and `stat_retry_cnt`, then go to BACKOFF.
    - Otherwise pulse `src_err[grant]`, clear pending, increment `stat_err_cnt`, go to IDLE.
  - **BACKOFF:** `vld=0`; count `BACKOFF` cycles, then return to ISSUE with the same grant and vec/fnc.
- ack and fail in the same cycle: ack wins.
- ack/fail outside ISSUE: ignored.
- Counters saturate at 16'hFFFF, no wrap.
- Reset, including mid-ISSUE: all pending cleared and FSM to IDLE. An in-flight QDMA interrupt is dropped without notification.

## Timing
- **Reset values:**
  - `usr_irq_in_vld`, vec, fnc, `src_done`, `src_err`, stats: 0.
  - `src_rdy`: all 1.
  - `rr_ptr`: 0.
- **Accept to vld:** `src_vld` accepted in cycle N.
  - `pending` is set at N+1, so IDLE can grant at N+1.
  - `usr_irq_in_vld` rises at N+2 (2-cycle latency from an idle arbiter).
- **Ack to done:** ack sampled in cycle M.
  - `vld` low and `src_done` high at M+1.
  - `src_rdy[grant]` high at M+2.
- **Back-to-back:** minimum one vld-low cycle between consecutive interrupts (the IDLE cycle).
- **Fail to retry:** fail at M gives vld low from M+1 to M+`BACKOFF`, then vld high at M+`BACKOFF`+1.
- **Outputs:** all registered; no combinational path from QDMA inputs to outputs.

## Structure
- Shared package `usr_irq_pkg`:
  - FSM state enum (IDLE/ISSUE/BACKOFF).
  - `IRQ_VEC_W=12`, `IRQ_FNC_W=8`, `STAT_W=16`.
- Sub-module `rr_pick`: combinational round-robin first-one search over `pending` from `rr_ptr`, returning `grant_idx` and `any`.

## Test plan
- Single source 0: vec=12'h005, fnc=8'h01; ack 3 cycles after vld rises.
  - vld rises 2 cycles after accept with vec=5, fnc=1.
  - `src_done[0]` pulses once; `stat_ack_cnt=1`.
- Sources 0..3 all request in the same cycle, QDMA acks immediately.
  - Grant order is 0,1,2,3 with one idle cycle between vld pulses.
  - Next round starting at source 2 grants 2 first.
- QDMA fails 2 times, then acks.
  - Vld issued 3 times, each gap = `BACKOFF`.
  - `stat_retry_cnt=2`; done pulses, no err.
- QDMA always fails with `MAX_RETRY=3`.
  - Exactly 4 issues, then `src_err` pulses and `stat_err_cnt=1`.
- QDMA silent.
  - vld drops after `TIMEOUT` cycles, retries as above, and ends in err.
- Remaining boundary cases:
  - ack+fail in the same cycle gives done.
  - Reset asserted mid-ISSUE gives vld=0 immediately and `src_rdy` all 1.
  - `src_vld` on a pending slot is ignored.
